// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared FSM type and default geometry for the direct-mapped data cache
package dcache_pkg;
    localparam int LINES_DEF  = 64;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2
    } state_t;
endpackage

// File: rtl/dcache_dm_if.sv
// rtl/dcache_dm_if.sv - memory-side request/response bus between the data cache and memory
interface dcache_dm_if
    import dcache_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              dm_en_o;
    logic              dm_wen_o;
    logic [ADDR_W-1:0] dm_addr_o;
    logic [DATA_W-1:0] dm_din_o;
    logic              dm_busy_i;
    logic              dm_rvalid_i;
    logic [DATA_W-1:0] dm_dout_i;

    modport master (
        output dm_en_o, dm_wen_o, dm_addr_o, dm_din_o,
        input  dm_busy_i, dm_rvalid_i, dm_dout_i
    );

    modport slave (
        input  dm_en_o, dm_wen_o, dm_addr_o, dm_din_o,
        output dm_busy_i, dm_rvalid_i, dm_dout_i
    );
endinterface

// File: rtl/dcache_wbuf.sv
// rtl/dcache_wbuf.sv - one-entry store buffer feeding write-through traffic to memory
module dcache_wbuf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              drain_ok,
    input  logic              mem_busy,
    output logic              full,
    output logic              req,
    output logic              accept,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);
    assign req    = full & drain_ok;
    assign accept = req & ~mem_busy;

    // A push in the same cycle the old entry is accepted simply replaces it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (push) begin
            full <= 1'b1;
            addr <= push_addr;
            data <= push_data;
        end else if (accept) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - direct-mapped, write-through, no-write-allocate data cache with one-entry write buffer
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int LINES  = LINES_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              x_dm_en_i,
    input  logic              x_dm_wen_i,
    input  logic [ADDR_W-1:0] x_dm_addr_i,
    input  logic [DATA_W-1:0] x_dm_din_i,
    input  logic              inv_i,
    output logic [DATA_W-1:0] m_dm_dout_o,
    output logic              dcache_stall_o,
    dcache_dm_if.master       mem
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];
    state_t            state_q, state_d;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] word_addr;
    logic              unused_addr_lsb;
    logic              hit, load, store, store_blocked, store_push, load_hit, fill;
    logic              miss_req, wb_drain_ok;
    logic              wb_full, wb_req, wb_accept;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    assign idx             = x_dm_addr_i[IDX_W+1:2];
    assign tag             = x_dm_addr_i[ADDR_W-1:IDX_W+2];
    assign word_addr       = {x_dm_addr_i[ADDR_W-1:2], 2'b00};
    assign unused_addr_lsb = ^x_dm_addr_i[1:0];

    // An invalidate in the request cycle forces a miss for that request.
    assign hit   = valid_q[idx] && (tag_q[idx] == tag) && !inv_i;
    assign load  = x_dm_en_i & ~x_dm_wen_i;
    assign store = x_dm_en_i & x_dm_wen_i;

    assign store_blocked = (state_q == IDLE) & store & wb_full & ~wb_accept;
    assign store_push    = (state_q == IDLE) & store & ~store_blocked;
    assign load_hit      = (state_q == IDLE) & load & hit;
    assign fill          = (state_q == MISS_WAIT) & mem.dm_rvalid_i;
    assign wb_drain_ok   = (state_q != MISS_WAIT);

    dcache_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (store_push),
        .push_addr (word_addr),
        .push_data (x_dm_din_i),
        .drain_ok  (wb_drain_ok),
        .mem_busy  (mem.dm_busy_i),
        .full      (wb_full),
        .req       (wb_req),
        .accept    (wb_accept),
        .addr      (wb_addr),
        .data      (wb_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (load && !hit) state_d = MISS_REQ;
            MISS_REQ:  if (miss_req && !mem.dm_busy_i) state_d = MISS_WAIT;
            MISS_WAIT: if (mem.dm_rvalid_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // The refill read waits for an empty write buffer so older stores reach memory first.
    always_comb begin
        miss_req       = 1'b0;
        dcache_stall_o = 1'b0;
        case (state_q)
            IDLE:      dcache_stall_o = (load & ~hit) | store_blocked;
            MISS_REQ:  begin
                miss_req       = ~wb_full;
                dcache_stall_o = 1'b1;
            end
            MISS_WAIT: dcache_stall_o = ~mem.dm_rvalid_i;
            default:   dcache_stall_o = 1'b0;
        endcase
    end

    assign mem.dm_en_o   = wb_req | miss_req;
    assign mem.dm_wen_o  = wb_req;
    assign mem.dm_addr_o = wb_req ? wb_addr : (miss_req ? word_addr : '0);
    assign mem.dm_din_o  = wb_req ? wb_data : '0;

    // A fill lands after a same-edge invalidate, so the refilled line stays valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            m_dm_dout_o <= '0;
        end else begin
            if (inv_i) valid_q <= '0;
            if (fill) begin
                valid_q[idx] <= 1'b1;
                tag_q[idx]   <= tag;
                data_q[idx]  <= mem.dm_dout_i;
                m_dm_dout_o  <= mem.dm_dout_i;
            end else if (load_hit) begin
                m_dm_dout_o  <= data_q[idx];
            end
            if (store_push && hit) data_q[idx] <= x_dm_din_i;
        end
    end
endmodule
